// File: rtl/dram_responder.sv
// Word-wide data-memory responder: one outstanding request, fixed access latency,
// byte-lane writes, and a held valid/ready response.
module dram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               we_q;
  logic [31:0]        mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic               oor;
  logic               access;

  assign idx    = addr_q[ADDR_WIDTH+1:2];
  // Any set bit above the word index is out of range; no aliasing into the array.
  assign oor    = (addr_q >> (ADDR_WIDTH + 2)) != 32'd0;
  assign access = rst_n && (state == BUSY) && (cnt == CNT_W'(0));

  always_ff @(posedge clk) begin
    if (access && we_q && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      cnt       <= CNT_W'(0);
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            we_q      <= req_we;
            wstrb_q   <= req_wstrb;
            wdata_q   <= req_wdata;
            cnt       <= CNT_W'(RD_LATENCY - 1);
            state     <= BUSY;
            req_ready <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt != CNT_W'(0)) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= oor;
            rsp_rdata <= (oor || we_q) ? 32'd0 : mem[idx];
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dram_responder.md
# dram_responder

Data-memory responder on the far side of the load/store path. Accepts one word-aligned request at a time from the core's memory stage and applies byte-lane writes from `wstrb`/`wdata`. Returns the full 32-bit word for reads after a programmable number of wait states, with a valid/ready response handshake. The core's load/store unit performs byte/halfword extraction and sign-extension; this block never shifts or extends data.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- `RD_LATENCY`, default 1: access latency in cycles, legal range 1..15, applied to reads and writes alike.

Ports:
- `clk` input 1: single clock; everything is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_addr` input 32: byte address; bits [1:0] are ignored; word index = `req_addr[ADDR_WIDTH+1:2]`.
- `req_we` input 1: 1 = write, 0 = read.
- `req_wstrb` input 4: byte-lane enables; bit i selects `wdata[8i+7:8i]`.
- `req_wdata` input 32: lane-positioned store data.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_rdata` output 32: read word; 0 for writes and errors.
- `rsp_err` output 1: address out of range.

## Operation
- States: IDLE, BUSY, RESP.
- `req_ready` = (state == IDLE). `rsp_valid` = (state == RESP).
- IDLE:
  - On `req_valid && req_ready` with `rst_n` high, latch addr/we/wstrb/wdata.
  - Load the 4-bit counter with `RD_LATENCY-1`, then go to BUSY.
- BUSY, counter != 0: decrement the counter.
- BUSY, counter == 0: perform the access and go to RESP.
  - Out of range: `req_addr[31:ADDR_WIDTH+2]` != 0. Set `rsp_err`=1 and `rsp_rdata`=0. The array is not touched.
  - Write: for each set `wstrb` bit, update that byte lane of the array word; other lanes are unchanged. `wstrb`=0000 leaves the array unchanged and is still acknowledged. `rsp_rdata`=0 and `rsp_err`=0.
  - Read: register the array word into `rsp_rdata` with `rsp_err`=0.
- RESP:
  - Hold `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready` is high.
  - On the handshake edge, go to IDLE and clear `rsp_rdata` and `rsp_err` to 0.
- Only one request is outstanding at a time; no pipelining.
- Requests are ordered, so a read following a write to the same word returns the merged data.
- Array contents are not reset; reads of never-written words return undefined data, and benches must not check them.

## Timing
- Reset values: state IDLE, `req_ready`=1 (once state is IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0.
- Reset has priority over everything:
  - A pending access is abandoned.
  - If the reset edge coincides with the BUSY access edge, no write occurs.
  - No response is issued for an abandoned request.
- Acceptance edge E0. `rsp_valid` rises after edge E0+RD_LATENCY, i.e. RD_LATENCY cycles after acceptance.
- With `rsp_ready` held high, the response handshake completes on the first RESP edge. `req_ready` is high again in the cycle after that edge.
- Minimum request-to-request spacing with `rsp_ready`=1 is RD_LATENCY+2 cycles.
- `req_*` inputs are sampled only on the acceptance edge; changes while BUSY or RESP have no effect.
- `req_ready` does not depend combinationally on `req_valid`.

## Test plan
- SW then LW (RD_LATENCY=1):
  - Stimulus: write 0x89ABCD12 to addr 0x10 with wstrb 1111, then read 0x10.
  - Required: `rsp_rdata`=0x89ABCD12, `rsp_err`=0; `rsp_valid` rises exactly 1 cycle after each acceptance edge.
- Lane merge:
  - Stimulus: from 0x89ABCD12 at 0x10, write wdata 0x00007800 with wstrb 0010, then write 0xEF010000 with wstrb 1100, then read 0x10.
  - Required: read returns 0xEF017812. A write with wstrb 0000 leaves it unchanged.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 3 cycles after `rsp_valid` rises.
  - Required: `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, and a `req_valid` pulse in that window is ignored (not accepted).
- Latency parameter:
  - Stimulus: RD_LATENCY=4, read of 0x20 accepted at cycle 5.
  - Required: `rsp_valid` first high in cycle 9.
- Out of range (ADDR_WIDTH=10):
  - Stimulus: write 0xDEADBEEF to 0x1000, then read 0x0000.
  - Required: the write response has `rsp_err`=1; word 0 keeps its prior value (wrap-around aliasing prohibited).
- Reset mid-operation:
  - Stimulus: write 0xFFFFFFFF to 0x10 (holding 0x89ABCD12) with RD_LATENCY=3; drive `rst_n`=0 for one edge while BUSY.
  - Required: no response; all outputs at reset values; a subsequent read of 0x10 returns 0x89ABCD12.
